morse_seq_buffer: RTL

//   Parametrised storage for the Morse sequence codes produced by the sequence separator.

---
 rtl/morse_pkg.sv | 21 ++
 rtl/morse_lane_pack.sv | 39 +++
 rtl/morse_seq_buffer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/morse_pkg.sv
// Shared definitions for the Morse sequence buffer: validity tag, fill pattern and lane check.
package morse_pkg;

    localparam logic [1:0]  SEQ_TAG_INVALID = 2'b11;
    localparam int unsigned SEQ_W_MAX       = 64;

    // All-ones pattern of width w, returned right-aligned in a SEQ_W_MAX-wide word.
    function automatic logic [SEQ_W_MAX-1:0] seq_fill(input int unsigned w);
        logic [SEQ_W_MAX-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < SEQ_W_MAX; i++) begin
            if (i < w) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic seq_is_valid(input logic [1:0] tag);
        return tag != SEQ_TAG_INVALID;
    endfunction

endpackage

// File: rtl/morse_lane_pack.sv
// Compacts the two incoming lanes, dropping invalid-tagged codes and keeping lane order.
module morse_lane_pack
    import morse_pkg::*;
#(
    parameter int unsigned SEQ_W = 10
) (
    input  logic [SEQ_W-1:0] first_seq,
    input  logic [SEQ_W-1:0] sec_seq,
    output logic [1:0]       k,
    output logic [SEQ_W-1:0] older,
    output logic [SEQ_W-1:0] newer
);

    localparam logic [SEQ_W-1:0] FILL = SEQ_W'(seq_fill(SEQ_W));

    logic first_ok;
    logic sec_ok;

    always_comb begin
        first_ok = seq_is_valid(first_seq[SEQ_W-1 -: 2]);
        sec_ok   = seq_is_valid(sec_seq[SEQ_W-1 -: 2]);
        k        = 2'd0;
        older    = FILL;
        newer    = FILL;
        // A single surviving code always travels on the "newer" output.
        if (first_ok && sec_ok) begin
            k     = 2'd2;
            older = first_seq;
            newer = sec_seq;
        end else if (first_ok) begin
            k     = 2'd1;
            newer = first_seq;
        end else if (sec_ok) begin
            k     = 2'd1;
            newer = sec_seq;
        end
    end

endmodule

// File: rtl/morse_seq_buffer.sv
// Morse sequence code store: shift-in push of up to two codes, oldest-first drain, snapshot port.
module morse_seq_buffer
    import morse_pkg::*;
#(
    parameter int unsigned SEQ_W     = 10,
    parameter int unsigned DEPTH     = 16,
    parameter bit          OVERWRITE = 1'b0,
    localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   sent_flag,
    input  logic [SEQ_W-1:0]       first_seq,
    input  logic [SEQ_W-1:0]       sec_seq,
    input  logic                   enter,
    output logic [DEPTH*SEQ_W-1:0] o_sequence,
    output logic                   snap_valid,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [SEQ_W-1:0]       rd_data,
    output logic [CW-1:0]          count,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow
);

    localparam logic [SEQ_W-1:0] FILL = SEQ_W'(seq_fill(SEQ_W));

    logic [SEQ_W-1:0]       slot_q [DEPTH];
    logic [SEQ_W-1:0]       slot_d [DEPTH];
    logic [SEQ_W-1:0]       slot_p [DEPTH];
    logic [CW-1:0]          count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic [DEPTH*SEQ_W-1:0] snap_q, snap_d;
    logic                   snap_valid_q, snap_valid_d;

    logic [1:0]             k;
    logic [SEQ_W-1:0]       older;
    logic [SEQ_W-1:0]       newer;
    logic                   pop;
    int unsigned            cnt_p;
    int unsigned            acc;
    int unsigned            drop;

    morse_lane_pack #(
        .SEQ_W (SEQ_W)
    ) u_lane_pack (
        .first_seq (first_seq),
        .sec_seq   (sec_seq),
        .k         (k),
        .older     (older),
        .newer     (newer)
    );

    assign count      = count_q;
    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign rd_valid   = !empty;
    assign overflow   = overflow_q;
    assign o_sequence = snap_q;
    assign snap_valid = snap_valid_q;

    always_comb begin
        rd_data = FILL;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (i + 1 == 32'(count_q)) rd_data = slot_q[i];
        end
    end

    // Pop retires the oldest slot first; the push then shifts into the reduced occupancy.
    always_comb begin
        pop    = rd_valid && rd_ready;
        slot_p = slot_q;
        cnt_p  = 32'(count_q);
        if (pop) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (i + 1 == cnt_p) slot_p[i] = FILL;
            end
            cnt_p = cnt_p - 1;
        end

        acc  = 0;
        drop = 0;
        if (sent_flag) begin
            if (OVERWRITE) begin
                acc  = 32'(k);
                drop = (cnt_p + acc > DEPTH) ? cnt_p + acc - DEPTH : 0;
            end else begin
                acc  = (32'(k) < DEPTH - cnt_p) ? 32'(k) : DEPTH - cnt_p;
                drop = 32'(k) - acc;
            end
        end

        // With only one lane accepted out of two, it is the older lane that lands in slot 0.
        slot_d = slot_p;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (i < acc) begin
                slot_d[i] = (i + 1 == acc && k == 2'd2) ? older : newer;
            end else begin
                slot_d[i] = slot_p[i - acc];
            end
        end

        count_d    = CW'((cnt_p + acc > DEPTH) ? DEPTH : cnt_p + acc);
        overflow_d = overflow_q || (drop != 0);

        if (clear) begin
            for (int unsigned i = 0; i < DEPTH; i++) slot_d[i] = FILL;
            count_d    = '0;
            overflow_d = 1'b0;
        end
    end

    always_comb begin
        snap_d       = snap_q;
        snap_valid_d = enter;
        if (enter) begin
            for (int unsigned i = 0; i < DEPTH; i++) snap_d[i*SEQ_W +: SEQ_W] = slot_q[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) slot_q[i] <= FILL;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            snap_q       <= '1;
            snap_valid_q <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            snap_q       <= snap_d;
            snap_valid_q <= snap_valid_d;
        end
    end

endmodule
